sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter that multiplexes NR read clients and
// NW write clients onto one asynchronous 16-bit SRAM. Each transaction
// holds the strobes for ACCESS_CYCLES cycles, then spends one DONE cycle
// with all strobes high while the granted client's ready bit pulses.
module sram_arbiter #(
  parameter int NR            = 2,
  parameter int NW            = 2,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NR-1:0]     rd_req,
  input  logic [NR*20-1:0]  rd_addr,
  output logic [NR-1:0]     rd_ready,
  output logic [15:0]       rd_data,
  input  logic [NW-1:0]     wr_req,
  input  logic [NW*20-1:0]  wr_addr,
  input  logic [NW*16-1:0]  wr_data,
  output logic [NW-1:0]     wr_ready,
  output logic [19:0]       sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int N  = NR + NW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(ACCESS_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   grant_idx_r;
  logic            is_write_r;

  logic [N-1:0]    req_all_s;
  logic            any_found_s, up_found_s, grant_found_s, grant_write_s;
  logic [IW-1:0]   any_idx_s, up_idx_s, grant_idx_s;
  logic [19:0]     grant_addr_s;
  logic [15:0]     grant_data_s;
  logic            do_grant_s, last_access_s, write_s;

  logic            oe_n_r, we_n_r, ub_n_r, lb_n_r, dq_oe_r;
  logic            oe_n_s, we_n_s, ub_n_s, lb_n_s, dq_oe_s;
  logic [19:0]     addr_r, addr_s;
  logic [15:0]     dq_out_r, dq_out_s, rd_data_r, rd_data_s;
  logic [NR-1:0]   rd_ready_r, rd_ready_s;
  logic [NW-1:0]   wr_ready_r, wr_ready_s;

  assign req_all_s     = {wr_req, rd_req};
  assign do_grant_s    = (state_r == ST_IDLE) && grant_found_s;
  assign last_access_s = (cnt_r == CW'(ACCESS_CYCLES - 1));

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    any_found_s = 1'b0;
    up_found_s  = 1'b0;
    any_idx_s   = '0;
    up_idx_s    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_all_s[i]) begin
        any_found_s = 1'b1;
        any_idx_s   = IW'(i);
        if (IW'(i) >= rr_ptr_r) begin
          up_found_s = 1'b1;
          up_idx_s   = IW'(i);
        end else begin
          up_found_s = up_found_s;
        end
      end else begin
        any_found_s = any_found_s;
      end
    end
    grant_found_s = any_found_s;
    if (up_found_s) begin
      grant_idx_s = up_idx_s;
    end else begin
      grant_idx_s = any_idx_s;
    end
    grant_write_s = (grant_idx_s >= IW'(NR));
  end

  // Address/data mux for the candidate grant.
  always_comb begin
    grant_addr_s = 20'h00000;
    grant_data_s = 16'h0000;
    for (int i = 0; i < NR; i++) begin
      if (grant_idx_s == IW'(i)) begin
        grant_addr_s = rd_addr[20*i +: 20];
      end else begin
        grant_addr_s = grant_addr_s;
      end
    end
    for (int i = 0; i < NW; i++) begin
      if (grant_idx_s == IW'(NR + i)) begin
        grant_addr_s = wr_addr[20*i +: 20];
        grant_data_s = wr_data[16*i +: 16];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // FSM state and access-cycle counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: IDLE -> ACCESS (ACCESS_CYCLES) -> DONE -> IDLE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          state_s = ST_ACCESS;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (last_access_s) begin
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Latch the granted client and advance the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r    <= '0;
      grant_idx_r <= '0;
      is_write_r  <= 1'b0;
    end else if (do_grant_s) begin
      grant_idx_r <= grant_idx_s;
      is_write_r  <= grant_write_s;
      rr_ptr_r    <= (grant_idx_s == IW'(N - 1)) ? IW'(0) : grant_idx_s + IW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Output decode from the upcoming state so every output is registered.
  always_comb begin
    write_s    = do_grant_s ? grant_write_s : is_write_r;
    oe_n_s     = 1'b1;
    we_n_s     = 1'b1;
    ub_n_s     = 1'b1;
    lb_n_s     = 1'b1;
    dq_oe_s    = 1'b0;
    rd_ready_s = '0;
    wr_ready_s = '0;
    addr_s     = addr_r;
    dq_out_s   = dq_out_r;
    rd_data_s  = rd_data_r;
    case (state_s)
      ST_ACCESS: begin
        ub_n_s  = 1'b0;
        lb_n_s  = 1'b0;
        oe_n_s  = write_s;
        we_n_s  = ~write_s;
        dq_oe_s = write_s;
      end
      ST_DONE: begin
        dq_oe_s = is_write_r;
        for (int i = 0; i < NR; i++) begin
          if (!is_write_r && (grant_idx_r == IW'(i))) begin
            rd_ready_s[i] = 1'b1;
          end else begin
            rd_ready_s[i] = 1'b0;
          end
        end
        for (int i = 0; i < NW; i++) begin
          if (is_write_r && (grant_idx_r == IW'(NR + i))) begin
            wr_ready_s[i] = 1'b1;
          end else begin
            wr_ready_s[i] = 1'b0;
          end
        end
      end
      ST_IDLE: oe_n_s = 1'b1;
      default: oe_n_s = 1'b1;
    endcase
    if (do_grant_s) begin
      addr_s = grant_addr_s;
      if (grant_write_s) begin
        dq_out_s = grant_data_s;
      end else begin
        dq_out_s = dq_out_r;
      end
    end else begin
      addr_s = addr_r;
    end
    if ((state_r == ST_ACCESS) && last_access_s && !is_write_r) begin
      rd_data_s = sram_dq_in;
    end else begin
      rd_data_s = rd_data_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oe_n_r     <= 1'b1;
      we_n_r     <= 1'b1;
      ub_n_r     <= 1'b1;
      lb_n_r     <= 1'b1;
      dq_oe_r    <= 1'b0;
      addr_r     <= 20'h00000;
      dq_out_r   <= 16'h0000;
      rd_data_r  <= 16'h0000;
      rd_ready_r <= '0;
      wr_ready_r <= '0;
    end else begin
      oe_n_r     <= oe_n_s;
      we_n_r     <= we_n_s;
      ub_n_r     <= ub_n_s;
      lb_n_r     <= lb_n_s;
      dq_oe_r    <= dq_oe_s;
      addr_r     <= addr_s;
      dq_out_r   <= dq_out_s;
      rd_data_r  <= rd_data_s;
      rd_ready_r <= rd_ready_s;
      wr_ready_r <= wr_ready_s;
    end
  end

  assign sram_oe_n   = oe_n_r;
  assign sram_we_n   = we_n_r;
  assign sram_ub_n   = ub_n_r;
  assign sram_lb_n   = lb_n_r;
  assign sram_dq_oe  = dq_oe_r;
  assign sram_addr   = addr_r;
  assign sram_dq_out = dq_out_r;
  assign rd_data     = rd_data_r;
  assign rd_ready    = rd_ready_r;
  assign wr_ready    = wr_ready_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a transaction-level model (grant ring plus a
// per-transaction cycle count) predicts every output on every falling edge;
// directed scenarios pin the model with hand-computed literals.
module tb_sram_arbiter;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AC = 2;
  localparam int N  = NR + NW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     rd_req = '0;
  logic [NR*20-1:0]  rd_addr = '0;
  logic [NR-1:0]     rd_ready;
  logic [15:0]       rd_data;
  logic [NW-1:0]     wr_req = '0;
  logic [NW*20-1:0]  wr_addr = '0;
  logic [NW*16-1:0]  wr_data = '0;
  logic [NW-1:0]     wr_ready;
  logic [19:0]       sram_addr;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_in;
  logic              sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int n_checks = 0;
  int n_err    = 0;

  sram_arbiter #(.NR(NR), .NW(NW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // SRAM contents as a fixed function of address (0x00123 -> 0xBEEF).
  function automatic logic [15:0] sram_fn(input logic [19:0] a);
    return a[15:0] ^ 16'hBFCC ^ {12'h000, a[19:16]};
  endfunction
  assign sram_dq_in = sram_fn(sram_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_grant(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [19:0] addr_of(input int g);
    if (g < NR) return rd_addr[20*g +: 20];
    return wr_addr[20*(g-NR) +: 20];
  endfunction

  function automatic logic rdy_of(input int cl);
    if (cl < NR) return rd_ready[cl];
    return wr_ready[cl-NR];
  endfunction

  // ---------------- reference model ----------------
  logic        m_busy, m_wr;
  int          m_t, m_idx, m_rr, m_g;
  logic [19:0] m_addr;
  logic [15:0] m_dqout, m_rdata;

  assign m_g = find_grant({wr_req, rd_req}, m_rr);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_wr <= 1'b0; m_t <= 0; m_idx <= 0; m_rr <= 0;
      m_addr <= '0; m_dqout <= '0; m_rdata <= '0;
    end else if (!m_busy) begin
      if (m_g >= 0) begin
        m_busy <= 1'b1;
        m_t    <= 1;
        m_idx  <= m_g;
        m_wr   <= (m_g >= NR);
        m_addr <= addr_of(m_g);
        if (m_g >= NR) m_dqout <= wr_data[16*(m_g-NR) +: 16];
        m_rr   <= (m_g + 1) % N;
      end
    end else begin
      if (m_t == AC && !m_wr) m_rdata <= sram_fn(m_addr);
      if (m_t == AC + 1) m_busy <= 1'b0;
      else m_t <= m_t + 1;
    end
  end

  wire m_acc = m_busy && (m_t <= AC);
  wire m_dn  = m_busy && (m_t == AC + 1);
  wire [NR-1:0] exp_rd_rdy = (m_dn && !m_wr) ? (NR'(1) << m_idx) : '0;
  wire [NW-1:0] exp_wr_rdy = (m_dn && m_wr) ? (NW'(1) << (m_idx - NR)) : '0;

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("oe_n",     sram_oe_n,   !(m_acc && !m_wr));
    chk("we_n",     sram_we_n,   !(m_acc && m_wr));
    chk("ub_n",     sram_ub_n,   !m_acc);
    chk("lb_n",     sram_lb_n,   !m_acc);
    chk("dq_oe",    sram_dq_oe,  m_busy && m_wr);
    chk("addr",     sram_addr,   m_addr);
    chk("dq_out",   sram_dq_out, m_dqout);
    chk("rd_data",  rd_data,     m_rdata);
    chk("rd_ready", rd_ready,    exp_rd_rdy);
    chk("wr_ready", wr_ready,    exp_wr_rdy);
    chk("one_hot_ready", ($countones({rd_ready, wr_ready}) <= 1), 1'b1);
  end

  // ---------------- directed helpers ----------------
  task automatic set_req(input int cl, input logic v);
    if (cl < NR) rd_req[cl] = v;
    else wr_req[cl-NR] = v;
  endtask

  task automatic single_txn(input int cl, input logic [19:0] a, input logic [15:0] d,
                            output int oe_low, output int we_low, output int dqoe_hi,
                            output int rdy_cnt, output int rdy_cyc,
                            output logic [15:0] rdat, output logic [15:0] dqo,
                            output logic [19:0] seen_addr);
    oe_low = 0; we_low = 0; dqoe_hi = 0; rdy_cnt = 0; rdy_cyc = 0;
    rdat = '0; dqo = '0; seen_addr = '0;
    if (cl < NR) rd_addr[20*cl +: 20] = a;
    else begin
      wr_addr[20*(cl-NR) +: 20] = a;
      wr_data[16*(cl-NR) +: 16] = d;
    end
    set_req(cl, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!sram_oe_n) begin oe_low++; seen_addr = sram_addr; end
      if (!sram_we_n) begin we_low++; seen_addr = sram_addr; end
      if (sram_dq_oe) begin dqoe_hi++; dqo = sram_dq_out; end
      if (rdy_of(cl)) begin
        rdy_cnt++;
        if (rdy_cyc == 0) rdy_cyc = c;
        rdat = rd_data;
        set_req(cl, 1'b0);
      end
    end
  endtask

  int oe_low, we_low, dqoe_hi, rdy_cnt, rdy_cyc, bad, first_idx, nev;
  logic [15:0] rdat, dqo;
  logic [19:0] saddr;
  int ord[8];
  int cyc[8];

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_oe_n", sram_oe_n, 1'b1);
    chk("reset_addr", sram_addr, 20'h00000);
    chk("reset_rd_data", rd_data, 16'h0000);
    chk("reset_dq_oe", sram_dq_oe, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Single read of client 0.
    single_txn(0, 20'h00123, 16'h0000, oe_low, we_low, dqoe_hi, rdy_cnt, rdy_cyc, rdat, dqo, saddr);
    chk("rd_oe_low", oe_low, 2);
    chk("rd_we_low", we_low, 0);
    chk("rd_addr_bus", saddr, 20'h00123);
    chk("rd_ready_cnt", rdy_cnt, 1);
    chk("rd_ready_cyc", rdy_cyc, 3);
    chk("rd_data_beef", rdat, 16'hBEEF);

    // Single write of write client 1 at the top address.
    single_txn(3, 20'hFFFFF, 16'h5A5A, oe_low, we_low, dqoe_hi, rdy_cnt, rdy_cyc, rdat, dqo, saddr);
    chk("wr_we_low", we_low, 2);
    chk("wr_oe_low", oe_low, 0);
    chk("wr_dqoe_hi", dqoe_hi, 3);
    chk("wr_dq_out", dqo, 16'h5A5A);
    chk("wr_addr_bus", saddr, 20'hFFFFF);
    chk("wr_ready_cnt", rdy_cnt, 1);
    chk("wr_rd_data_kept", rd_data, 16'hBEEF);

    // Read client 1 drops its request during ACCESS.
    rd_addr[20 +: 20] = 20'h00456;
    rd_req[1] = 1'b1;
    @(negedge clk);
    rd_req[1] = 1'b0;
    rdy_cnt = 0; oe_low = 1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (rd_ready[1]) rdy_cnt++;
      if (!sram_oe_n) oe_low++;
    end
    chk("drop_ready_cnt", rdy_cnt, 1);
    chk("drop_oe_low", oe_low, 2);

    // Ten idle cycles, then all four request: rr resumes after client 1.
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!sram_oe_n || !sram_we_n || !sram_ub_n || !sram_lb_n || sram_dq_oe) bad++;
    end
    chk("idle_strobes", bad, 0);
    rd_req = '1; wr_req = '1;
    first_idx = -1;
    for (int c = 0; c < 10 && first_idx < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (rdy_of(i)) first_idx = i;
    end
    chk("idle_rr_kept", first_idx, 2);

    // All four held from reset release: strict ring order, one every 4 cycles.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    nev = 0;
    for (int c = 1; c <= 40 && nev < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rdy_of(i) && nev < 8) begin ord[nev] = i; cyc[nev] = c; nev++; end
      end
    end
    chk("rr_events", nev, 8);
    bad = 0;
    for (int k = 0; k < 8; k++) if (ord[k] != (k % 4)) bad++;
    chk("rr_order", bad, 0);
    chk("rr_first_cyc", cyc[0], 3);
    bad = 0;
    for (int k = 1; k < 8; k++) if (cyc[k] - cyc[k-1] != 4) bad++;
    chk("rr_spacing", bad, 0);

    // Reset in the second ACCESS cycle of a write.
    reset = 1'b0;
    rd_req = '0; wr_req = 2'b01;
    wr_addr[19:0] = 20'h0ABCD;
    wr_data[15:0] = 16'hC3C3;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_we_low", sram_we_n, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_we_n", sram_we_n, 1'b1);
    chk("rst_mid_dq_oe", sram_dq_oe, 1'b0);
    chk("rst_mid_ub_n", sram_ub_n, 1'b1);
    @(negedge clk);
    chk("rst_mid_no_ready", wr_ready, 2'b00);
    reset = 1'b1;
    rdy_cnt = 0; rdy_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (wr_ready[0]) begin
        rdy_cnt++;
        if (rdy_cyc == 0) rdy_cyc = c;
        wr_req[0] = 1'b0;
      end
    end
    chk("rst_regrant_cnt", rdy_cnt, 1);
    chk("rst_regrant_cyc", rdy_cyc, 3);

    // Randomized traffic with clients honouring the hold-until-ready rule.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        logic cur;
        cur = (i < NR) ? rd_req[i] : wr_req[i-NR];
        if (rdy_of(i) || (!cur && $urandom_range(0, 3) == 0)) begin
          if (i < NR) rd_addr[20*i +: 20] = 20'($urandom);
          else begin
            wr_addr[20*(i-NR) +: 20] = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
            wr_data[16*(i-NR) +: 16] = 16'($urandom);
          end
          set_req(i, rdy_of(i) ? 1'($urandom_range(0, 1)) : 1'b1);
        end else if (cur && $urandom_range(0, 49) == 0) begin
          set_req(i, 1'b0);
        end
      end
    end
    rd_req = '0; wr_req = '0;
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
